// File: rtl/lc3_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg
// Shared definitions for the LC-3 register file slice.
//   DATA_W           default datapath width
//   DR_R7            destination index used for JSR/TRAP link writes
//   nzp_t            packed {n,z,p} condition-code type
//   NZP_N/NZP_Z/NZP_P one-hot condition-code constants
// -----------------------------------------------------------------------------
package lc3_pkg;

   localparam int DATA_W = 16;

   localparam logic [2:0] DR_R7 = 3'b111;

   typedef struct packed {
      logic n;
      logic z;
      logic p;
   } nzp_t;

   localparam nzp_t NZP_N = 3'b100;
   localparam nzp_t NZP_Z = 3'b010;
   localparam nzp_t NZP_P = 3'b001;

endpackage : lc3_pkg

// File: rtl/nzp_gen.sv
// -----------------------------------------------------------------------------
// nzp_gen
// Combinational condition-code derivation from a datapath value.
// Ports:
//   value_i  DATA_W  value to classify (two's complement)
//   nzp_o    nzp_t   one-hot {n,z,p}: negative, zero or positive
// -----------------------------------------------------------------------------
module nzp_gen
   import lc3_pkg::nzp_t;
   import lc3_pkg::NZP_N;
   import lc3_pkg::NZP_Z;
   import lc3_pkg::NZP_P;
#(
   parameter int DATA_W = lc3_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] value_i,
   output nzp_t              nzp_o
);

   // The sign bit is tested first, so exactly one code is ever produced.
   always_comb begin
      if (value_i[DATA_W-1]) begin
         nzp_o = NZP_N;
      end else if (value_i == '0) begin
         nzp_o = NZP_Z;
      end else begin
         nzp_o = NZP_P;
      end
   end

endmodule : nzp_gen

// File: rtl/lc3_regfile.sv
// -----------------------------------------------------------------------------
// lc3_regfile
// LC-3 general-purpose register file (R0..R7) plus the NZP condition codes.
// Ports:
//   Clk        clock, all state changes on the rising edge
//   Reset_n    synchronous active-low reset
//   BUS        write data and condition-code source
//   IR         instruction register; IR[11:9] is the default destination
//   DRMUX_SEL  0: destination = IR[11:9], 1: destination = R7
//   LD_REG     register write enable
//   LD_CC      condition-code load enable
//   reg1_out..reg8_out  registered R0..R7
//   NZP        registered condition codes {N,Z,P}
// -----------------------------------------------------------------------------
module lc3_regfile #(
   parameter int              DATA_W    = lc3_pkg::DATA_W,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [DATA_W-1:0] BUS,
   input  logic [15:0]       IR,
   input  logic              DRMUX_SEL,
   input  logic              LD_REG,
   input  logic              LD_CC,
   output logic [DATA_W-1:0] reg1_out,
   output logic [DATA_W-1:0] reg2_out,
   output logic [DATA_W-1:0] reg3_out,
   output logic [DATA_W-1:0] reg4_out,
   output logic [DATA_W-1:0] reg5_out,
   output logic [DATA_W-1:0] reg6_out,
   output logic [DATA_W-1:0] reg7_out,
   output logic [DATA_W-1:0] reg8_out,
   output logic [2:0]        NZP
);

   import lc3_pkg::nzp_t;
   import lc3_pkg::DR_R7;
   import lc3_pkg::NZP_Z;

   logic [2:0]        dr;
   logic [DATA_W-1:0] regs_q [8];
   logic [DATA_W-1:0] regs_d [8];
   nzp_t              nzp_q;
   nzp_t              nzp_d;
   nzp_t              nzp_bus;

   // Only the destination field of IR matters here; the opcode and source
   // fields are decoded elsewhere in the datapath.
   logic unused_ir;
   assign unused_ir = ^{IR[15:12], IR[8:0]};

   // Link writes (JSR/TRAP) always target R7 regardless of IR.
   assign dr = DRMUX_SEL ? DR_R7 : IR[11:9];

   nzp_gen #(
      .DATA_W (DATA_W)
   ) u_nzp_gen (
      .value_i (BUS),
      .nzp_o   (nzp_bus)
   );

   // NOTE: every combinational output gets a default first so a missing
   // branch holds the current value instead of inferring a latch.
   always_comb begin
      regs_d = regs_q;
      nzp_d  = nzp_q;
      if (LD_REG) begin
         regs_d[dr] = BUS;
      end
      if (LD_CC) begin
         nzp_d = nzp_bus;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   // NOTE: the array is only eight flop words, so it is reset entry by entry
   // like any other register rather than being left to a RAM macro.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= RESET_VAL;
         end
         nzp_q <= NZP_Z;
      end else begin
         regs_q <= regs_d;
         nzp_q  <= nzp_d;
      end
   end

   // Outputs come straight from the storage flops; no write-through path.
   assign reg1_out = regs_q[0];
   assign reg2_out = regs_q[1];
   assign reg3_out = regs_q[2];
   assign reg4_out = regs_q[3];
   assign reg5_out = regs_q[4];
   assign reg6_out = regs_q[5];
   assign reg7_out = regs_q[6];
   assign reg8_out = regs_q[7];
   assign NZP      = nzp_q;

endmodule : lc3_regfile

// File: tb/tb_lc3_regfile.sv
// -----------------------------------------------------------------------------
// tb_lc3_regfile
// Directed stimulus for lc3_regfile with an array-based reference model that
// is compared against every DUT output on each falling edge after reset, plus
// literal expectations at key points of the sequence.
// -----------------------------------------------------------------------------
module tb_lc3_regfile;

   logic        clk;
   logic        rst_n;
   logic [15:0] bus;
   logic [15:0] ir;
   logic        drmux_sel;
   logic        ld_reg;
   logic        ld_cc;
   logic [15:0] r_out [8];
   logic [2:0]  nzp;

   int total = 0;
   int bad   = 0;

   // Reference model
   logic [15:0] m_reg [8];
   logic [2:0]  m_nzp;
   bit          m_valid = 1'b0;

   lc3_regfile #(
      .DATA_W    (16),
      .RESET_VAL (16'h0000)
   ) dut (
      .Clk       (clk),
      .Reset_n   (rst_n),
      .BUS       (bus),
      .IR        (ir),
      .DRMUX_SEL (drmux_sel),
      .LD_REG    (ld_reg),
      .LD_CC     (ld_cc),
      .reg1_out  (r_out[0]),
      .reg2_out  (r_out[1]),
      .reg3_out  (r_out[2]),
      .reg4_out  (r_out[3]),
      .reg5_out  (r_out[4]),
      .reg6_out  (r_out[5]),
      .reg7_out  (r_out[6]),
      .reg8_out  (r_out[7]),
      .NZP       (nzp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model update: apply the rules to the inputs seen at each rising edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
         m_nzp   = 3'b010;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (ld_reg) m_reg[drmux_sel ? 7 : int'(ir[11:9])] = bus;
         if (ld_cc) begin
            if (bus[15])           m_nzp = 3'b100;
            else if (bus == 16'h0) m_nzp = 3'b010;
            else                   m_nzp = 3'b001;
         end
      end
   end

   // Continuous compare against the model once reset has been applied.
   always @(negedge clk) begin
      if (m_valid) begin
         for (int i = 0; i < 8; i++) begin
            check($sformatf("model_r%0d", i), r_out[i], m_reg[i]);
         end
         check("model_nzp", {13'h0, nzp}, {13'h0, m_nzp});
         check("nzp_onehot", {15'h0, $onehot(nzp)}, 16'h0001);
      end
   end

   // One clock with the given inputs; returns #1 after the falling edge.
   task automatic step(input logic rst, input logic lr, input logic lc,
                       input logic sel, input logic [2:0] dr_f, input logic [15:0] b);
      rst_n     = rst;
      ld_reg    = lr;
      ld_cc     = lc;
      drmux_sel = sel;
      ir        = {4'hA, dr_f, 9'h1B5};
      bus       = b;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; ld_reg = 1'b0; ld_cc = 1'b0; drmux_sel = 1'b0;
      ir = 16'h0; bus = 16'h0;
      @(negedge clk);

      // Reset beats LD_REG/LD_CC with an all-ones bus.
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 16'hFFFF);
      for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), r_out[i], 16'h0000);
      check("rst_nzp", {13'h0, nzp}, 16'h0002);

      // Plain write through IR[11:9].
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h1234);
      check("wr_r3", r_out[3], 16'h1234);
      check("wr_r0_hold", r_out[0], 16'h0000);
      check("wr_r4_hold", r_out[4], 16'h0000);

      // Link write to R7 ignores IR[11:9].
      step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 16'h3001);
      check("link_r7", r_out[7], 16'h3001);
      check("link_r0_hold", r_out[0], 16'h0000);

      // Condition codes only.
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h8000);
      check("cc_neg", {13'h0, nzp}, 16'h0004);
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000);
      check("cc_zero", {13'h0, nzp}, 16'h0002);
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0001);
      check("cc_pos", {13'h0, nzp}, 16'h0001);
      check("cc_r0_hold", r_out[0], 16'h0000);

      // LD_CC=0 holds NZP even with a negative bus.
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'hF000);
      check("cc_hold", {13'h0, nzp}, 16'h0001);

      // Register write and CC load on the same bus value.
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 16'hFFFE);
      check("both_r5", r_out[5], 16'hFFFE);
      check("both_nzp", {13'h0, nzp}, 16'h0004);

      // Reset in the middle of a write sequence discards the write.
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'hAAAA);
      check("pre_rst_r2", r_out[2], 16'hAAAA);
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 16'h5555);
      check("mid_rst_r2", r_out[2], 16'h0000);
      check("mid_rst_r3", r_out[3], 16'h0000);
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h5555);
      check("post_rst_r2", r_out[2], 16'h5555);

      // Back-to-back writes to the same register.
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h1111);
      check("b2b_first", r_out[1], 16'h1111);
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h2222);
      check("b2b_last", r_out[1], 16'h2222);

      // LD_REG=0 holds everything.
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'hDEAD);
      check("hold_r1", r_out[1], 16'h2222);

      // Fill every register through IR, then link-write with IR pointing at R2.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 3'(i), 16'h0101 * 16'(i) + 16'h7F00);
      end
      check("fill_r0", r_out[0], 16'h7F00);
      check("fill_r6", r_out[6], 16'h8506);
      check("fill_nzp", {13'h0, nzp}, 16'h0004);
      step(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0042);
      check("link2_r7", r_out[7], 16'h0042);
      check("link2_r2_hold", r_out[2], 16'h8102);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule : tb_lc3_regfile
